// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions: opcode encodings, instruction field positions,
// instruction-memory extent and the fetch state encoding.
package cpu_isa_pkg;

  localparam int OPCODE_HI = 31;
  localparam int OPCODE_LO = 26;
  localparam int IMM26_HI  = 25;
  localparam int IMM26_LO  = 0;

  localparam logic [5:0] OP_NOP   = 6'b000000;
  localparam logic [5:0] OP_ADD   = 6'b000001;
  localparam logic [5:0] OP_SUB   = 6'b000010;
  localparam logic [5:0] OP_MUL   = 6'b000011;
  localparam logic [5:0] OP_AND   = 6'b000100;
  localparam logic [5:0] OP_OR    = 6'b000101;
  localparam logic [5:0] OP_XOR   = 6'b000110;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LOAD  = 6'b010000;
  localparam logic [5:0] OP_STORE = 6'b010001;
  localparam logic [5:0] OP_JUMP  = 6'b010101;
  localparam logic [5:0] OP_BRA   = 6'b010110;
  localparam logic [5:0] OP_ADDF  = 6'b100000;
  localparam logic [5:0] OP_SUBF  = 6'b100001;
  localparam logic [5:0] OP_MULF  = 6'b100010;

  localparam int IMEM_MAX_ADDR = 26;

  typedef enum logic {
    FETCH = 1'b0,
    FAULT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_next_pc.sv
// Next-PC selection for the fetch stage: redirect, early jump target,
// sequential increment, or hold.
module fetch_next_pc
  import cpu_isa_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32
) (
  input  logic [ADDR_W-1:0]  pc,
  input  logic [INSTR_W-1:0] instr,
  input  logic               load,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [ADDR_W-1:0]  next_pc
);

  logic is_jump;

  assign is_jump = (instr[OPCODE_HI:OPCODE_LO] == OP_JUMP);

  always_comb begin
    next_pc = pc;
    if (redirect_valid) begin
      next_pc = redirect_pc;
    end else if (load) begin
      // Jump target is the zero-extended 26-bit word address
      next_pc = is_jump ? ADDR_W'(instr[IMM26_HI:IMM26_LO]) : pc + 1'b1;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC register, one-entry fetch register with valid/ready
// toward decode, early jump resolution, branch redirect and range fault.
module instr_fetch_unit
  import cpu_isa_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int INSTR_W  = 32,
  parameter int MAX_ADDR = IMEM_MAX_ADDR,
  parameter int RESET_PC = 0
) (
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               if_ready,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  output logic               fault
);

  logic [ADDR_W-1:0]  pc_p0;
  logic [ADDR_W-1:0]  next_pc;
  logic [ADDR_W-1:0]  pc_p1;
  logic [INSTR_W-1:0] instr_p1;
  logic               vld_p1;
  logic               in_range;
  logic               load;
  fetch_state_t       state_q, state_d;

  assign in_range  = (pc_p0 <= ADDR_W'(MAX_ADDR));
  assign imem_addr = pc_p0;
  assign if_valid  = vld_p1;
  assign if_instr  = instr_p1;
  assign if_pc     = pc_p1;
  assign fault     = (state_q == FAULT);

  fetch_next_pc #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_next_pc (
    .pc             (pc_p0),
    .instr          (imem_data),
    .load           (load),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .next_pc        (next_pc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Redirect wins over everything but reset; an out-of-range PC halts fetch
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    if (redirect_valid) begin
      state_d = FETCH;
    end else if (state_q == FETCH) begin
      if (!in_range) begin
        state_d = FAULT;
      end else if (!vld_p1 || if_ready) begin
        load = 1'b1;
      end
    end
  end

  // p0 -> p1: PC register feeds memory; fetch register captures the returned word
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_p0    <= ADDR_W'(RESET_PC);
      vld_p1   <= 1'b0;
      instr_p1 <= '0;
      pc_p1    <= '0;
    end else begin
      pc_p0 <= next_pc;
      if (redirect_valid) begin
        vld_p1 <= 1'b0;
      end else if (load) begin
        vld_p1   <= 1'b1;
        instr_p1 <= imem_data;
        pc_p1    <= pc_p0;
      end else if (if_ready) begin
        vld_p1 <= 1'b0;
      end
    end
  end

endmodule
